pbus_addr_mux: RTL
==================

Name: pbus_addr_mux

Overview:
- Drives the multiplexed P address bus and the PCK1B/PCK2B latch strobes to the NEO-273 address latch.
- Takes one queued sprite C-ROM address and one queued fix S-ROM address from the video address generator.
- Time-multiplexes them onto P[19:0] in a fixed 16-phase schedule: C slot first, then S slot.
- Each strobe's rising edge lands with P stable on both sides of it.

Parameters:
- SETUP_PH, 2: phases P is held stable before the strobe falls.
- LOW_PH, 2: phases the strobe stays low; rising edge lands at slot phase SETUP_PH+LOW_PH.

Ports:
- CLK_24M  in  1  master clock; all logic on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- C_ADDR  in  20  sprite address, bit-packed exactly as the NEO-273 C latch expects.
- C_VALID  in  1  C_ADDR valid.
- C_READY  out  1  C buffer empty; transfer occurs when C_VALID&C_READY.
- S_ADDR  in  16  fix address, packed as the NEO-273 S latch expects.
- S_VALID  in  1  S_ADDR valid.
- S_READY  out  1  S buffer empty.
- P  out  20  multiplexed address bus.
- PCK1B  out  1  C latch strobe; idle high.
- PCK2B  out  1  S latch strobe; idle high.
- C_DONE  out  1  one-cycle pulse, C strobe has risen.
- S_DONE  out  1  one-cycle pulse, S strobe has risen.
- PHASE  out  4  current schedule phase.

Behaviour:
- All outputs are registered. "During phase n" means the cycle in which PHASE==n.
- Phase counter:
  - Free-running 0..15, wraps 15→0.
  - Phases 0-7 are slot A (C); phases 8-15 are slot B (S).
- Buffers:
  - One-entry buffer per channel. READY = ~full flag, with no same-cycle pass-through.
  - Accept on VALID&READY: store the address and set full.
  - Full clears on the edge ending the owning slot's phase 0 (C) or phase 8 (S), which is the load edge.
  - A new accept is possible from the next phase. READY is low in the load cycle itself.
- C slot, if the C buffer is full at the end of phase 0:
  - P <= C_ADDR buffer, valid during phases 1-8.
  - PCK1B low during phases 1+SETUP_PH .. SETUP_PH+LOW_PH (default 3-4); high again from phase 5.
  - C_DONE high during phase 5.
  - P is stable ≥SETUP_PH+LOW_PH cycles before and ≥3 cycles after the rising edge.
- S slot: same timing offset by 8.
  - P <= {4'b0, S buffer}.
  - PCK2B low phases 11-12, high from 13.
  - S_DONE high during phase 13.
- Empty slot (buffer empty at the load edge):
  - No strobe, no DONE.
  - P holds its previous value.
- Invariants:
  - Strobes are never low simultaneously.
  - P never changes while either strobe is low.
  - Each accepted address produces exactly one strobe rising edge and one DONE.
- Arrival timing:
  - An address accepted during the load cycle of its slot misses that slot and waits one full 16-phase period.
  - Worst-case accept→DONE latency is 21 cycles.
- Reset:
  - Applies on any clock with RESET=1.
  - PHASE=0; buffers empty; READY=0 while RESET=1 and 1 from the first cycle after; PCK1B=PCK2B=1; C_DONE=S_DONE=0.
  - P clears to 0 only on a reset edge where both strobes are already high; otherwise P holds for that edge. This prevents a strobe rising while P changes.
  - Consequence: a reset asserted mid-strobe completes that strobe's rising edge with the old address, and clears P on the next reset cycle.
  - A 2-cycle reset always yields P=0.
  - DONE is not asserted for a strobe cut short by reset.

Optional Feature:
- Macro: PBUS_SLOT_STEAL_EN.
- When defined:
  - At the phase-0 load edge, C empty and S full → S uses slot A. P={4'b0,S}, PCK2B low phases 3-4, S_DONE in phase 5.
  - Symmetrically, at phase 8, S empty and C full → C uses slot B: PCK1B low 11-12, C_DONE in phase 13.
  - Owner-channel priority is always preserved.
- When undefined: each channel uses only its own slot; an empty slot stays idle.

Test Plan:
- RESET 2 cycles, then idle 32 cycles → P=0, PCK1B=PCK2B=1, READY=1 from first post-reset cycle, no DONE, PHASE counts 0..15 twice.
- C_ADDR=20'hABCDE accepted in phase 10 → P=20'hABCDE phases 1-8 of next period, PCK1B low phases 3-4, C_DONE in phase 5, PCK2B stays high.
- C_ADDR=20'h12345 and S_ADDR=16'h9876 both accepted in phase 14 → C strobe at phase 5 rise; P=20'h09876 from phase 9, PCK2B low 11-12, S_DONE phase 13; strobes never overlap.
- C_VALID held high with C_ADDR incrementing from 0 for 4 periods → one accept per period, C_READY low only from accept edge until load edge, 4 C_DONE pulses, P sequence 0,1,2,3.
- RESET asserted 1 cycle during phase 3 with C strobe low → PCK1B high next cycle, P unchanged on that edge, no C_DONE; RESET for another cycle → P=0.
- PBUS_SLOT_STEAL_EN defined, only S_ADDR=16'h4321 pending at phase 0 → PCK2B low phases 3-4, S_DONE phase 5, P=20'h04321; undefined → strobe in phases 11-12 instead.

Source files
------------

// File: rtl/pbus_addr_mux.sv
// P-bus address multiplexer for the NEO-273 latch: one C and one S entry time-shared on P[19:0].
// Define PBUS_SLOT_STEAL_EN to let a channel borrow the other's idle slot.
module pbus_addr_mux #(
  parameter int SETUP_PH = 2,
  parameter int LOW_PH   = 2
) (
  input  logic        CLK_24M,
  input  logic        RESET,
  input  logic [19:0] C_ADDR,
  input  logic        C_VALID,
  output logic        C_READY,
  input  logic [15:0] S_ADDR,
  input  logic        S_VALID,
  output logic        S_READY,
  output logic [19:0] P,
  output logic        PCK1B,
  output logic        PCK2B,
  output logic        C_DONE,
  output logic        S_DONE,
  output logic [3:0]  PHASE
);

  // Slot-relative edges: strobe falls after SETUP_PH, rises at SETUP_PH+LOW_PH (must stay within 1..7).
  localparam logic [2:0] FALL_REL = 3'(SETUP_PH);
  localparam logic [2:0] RISE_REL = 3'(SETUP_PH + LOW_PH);

  logic [3:0]  r_phase;
  logic        r_c_full;
  logic        r_s_full;
  logic [19:0] r_c_buf;
  logic [15:0] r_s_buf;
  logic [19:0] r_p;
  logic        r_pck1b;
  logic        r_pck2b;
  logic        r_c_done;
  logic        r_s_done;
  logic        r_act;
  logic        r_act_s;

  logic [2:0]  w_rel;
  logic        w_slot_b;
  logic        w_load_edge;
  logic        w_load_c;
  logic        w_load_s;
  logic        w_c_acc;
  logic        w_s_acc;

  assign w_rel       = r_phase[2:0];
  assign w_slot_b    = r_phase[3];
  assign w_load_edge = (w_rel == 3'd0);

  always_comb begin
    w_load_c = w_load_edge & ~w_slot_b & r_c_full;
    w_load_s = w_load_edge &  w_slot_b & r_s_full;
`ifdef PBUS_SLOT_STEAL_EN
    if (w_load_edge & ~w_slot_b & ~r_c_full & r_s_full) w_load_s = 1'b1;
    if (w_load_edge &  w_slot_b & ~r_s_full & r_c_full) w_load_c = 1'b1;
`endif
  end

  // READY is masked by RESET so a handshake during reset is never seen as a transfer.
  assign C_READY = ~r_c_full & ~RESET;
  assign S_READY = ~r_s_full & ~RESET;
  assign w_c_acc = C_VALID & C_READY;
  assign w_s_acc = S_VALID & S_READY;

  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      r_phase  <= 4'd0;
      r_c_full <= 1'b0;
      r_s_full <= 1'b0;
      r_pck1b  <= 1'b1;
      r_pck2b  <= 1'b1;
      r_c_done <= 1'b0;
      r_s_done <= 1'b0;
      r_act    <= 1'b0;
      r_act_s  <= 1'b0;
      // A strobe cut short rises now with P held; P clears on a later reset edge.
      if (r_pck1b & r_pck2b) r_p <= 20'd0;
    end else begin
      r_phase  <= r_phase + 4'd1;
      r_c_done <= 1'b0;
      r_s_done <= 1'b0;

      if (w_c_acc) begin
        r_c_buf  <= C_ADDR;
        r_c_full <= 1'b1;
      end else if (w_load_c) begin
        r_c_full <= 1'b0;
      end

      if (w_s_acc) begin
        r_s_buf  <= S_ADDR;
        r_s_full <= 1'b1;
      end else if (w_load_s) begin
        r_s_full <= 1'b0;
      end

      if (w_load_c) begin
        r_p     <= r_c_buf;
        r_act   <= 1'b1;
        r_act_s <= 1'b0;
      end else if (w_load_s) begin
        r_p     <= {4'b0000, r_s_buf};
        r_act   <= 1'b1;
        r_act_s <= 1'b1;
      end

      if (r_act && (w_rel == FALL_REL)) begin
        if (r_act_s) r_pck2b <= 1'b0;
        else         r_pck1b <= 1'b0;
      end

      if (r_act && (w_rel == RISE_REL)) begin
        r_pck1b <= 1'b1;
        r_pck2b <= 1'b1;
        r_act   <= 1'b0;
        if (r_act_s) r_s_done <= 1'b1;
        else         r_c_done <= 1'b1;
      end
    end
  end

  assign P      = r_p;
  assign PCK1B  = r_pck1b;
  assign PCK2B  = r_pck2b;
  assign C_DONE = r_c_done;
  assign S_DONE = r_s_done;
  assign PHASE  = r_phase;

endmodule
